// File: rtl/packet_reassembler.sv
`default_nettype none
// =============================================================================
// packet_reassembler -- gathers flits into slots, emits whole packets in slot order
// Revision: 1.0
// =============================================================================
module packet_reassembler #(
   parameter int  NODE_COUNT       = 8,
   parameter int  PACKET_ID_WIDTH  = 5,
   parameter int  FLITS_PER_PACKET = 9,
   parameter int  DATA_W           = 8,
   parameter int  SLOTS            = 8,
   parameter int  TIMEOUT_CYCLES   = 1024,
   localparam int c_NODE_W         = $clog2(NODE_COUNT),
   localparam int c_IDX_W          = $clog2(FLITS_PER_PACKET),
   localparam int c_OCC_W          = $clog2(SLOTS + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [c_NODE_W-1:0]                  in_src,
   input  logic [c_NODE_W-1:0]                  in_dst,
   input  logic [PACKET_ID_WIDTH-1:0]           in_id,
   input  logic [c_IDX_W-1:0]                   in_idx,
   input  logic [DATA_W-1:0]                    in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [FLITS_PER_PACKET*DATA_W-1:0]   out_data,
   output logic [c_NODE_W-1:0]                  out_src,
   output logic [c_NODE_W-1:0]                  out_dst,
   output logic [PACKET_ID_WIDTH-1:0]           out_id,
   output logic [c_OCC_W-1:0]                   occupancy,
   output logic [15:0]                          drop_count,
   output logic [15:0]                          dup_count,
   output logic [15:0]                          timeout_count
);

   localparam int                          c_SLOT_W  = $clog2(SLOTS);
   localparam int                          c_AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FLITS_PER_PACKET-1:0] c_FULL    = '1;
   localparam logic [c_AGE_W-1:0]          c_AGE_MAX = c_AGE_W'(TIMEOUT_CYCLES);
   localparam logic [15:0]                 c_SAT     = 16'hFFFF;

   typedef enum logic [1:0] {
      S_FREE     = 2'd0,
      S_FILLING  = 2'd1,
      S_COMPLETE = 2'd2
   } slot_state_t;

   slot_state_t                r_state   [SLOTS];
   logic [c_NODE_W-1:0]        r_src     [SLOTS];
   logic [c_NODE_W-1:0]        r_dst     [SLOTS];
   logic [PACKET_ID_WIDTH-1:0] r_id      [SLOTS];
   logic [FLITS_PER_PACKET-1:0] r_mask   [SLOTS];
   logic [c_AGE_W-1:0]         r_age     [SLOTS];
   logic [DATA_W-1:0]          r_payload [SLOTS][FLITS_PER_PACKET];

   logic                                r_out_valid;
   logic [FLITS_PER_PACKET*DATA_W-1:0]  r_out_data;
   logic [c_NODE_W-1:0]                 r_out_src;
   logic [c_NODE_W-1:0]                 r_out_dst;
   logic [PACKET_ID_WIDTH-1:0]          r_out_id;
   logic [c_OCC_W-1:0]                  r_occupancy;
   logic [15:0]                         r_drop_count;
   logic [15:0]                         r_dup_count;
   logic [15:0]                         r_timeout_count;

   logic                                w_any_match, w_any_free, w_any_cmpl;
   logic [c_SLOT_W-1:0]                 w_match_idx, w_free_idx, w_cmpl_idx, w_wr_slot;
   logic                                w_oob, w_accept, w_hit, w_dup, w_alloc, w_load, w_unload;
   logic [FLITS_PER_PACKET-1:0]         w_onehot, w_new_mask;
   logic [SLOTS-1:0]                    w_evict;
   logic [c_OCC_W-1:0]                  w_evict_cnt;
   logic [FLITS_PER_PACKET*DATA_W-1:0]  w_cmpl_data;

   // Downward scan leaves the lowest matching index in each result.
   always_comb begin
      w_any_match = 1'b0;
      w_match_idx = '0;
      w_any_free  = 1'b0;
      w_free_idx  = '0;
      w_any_cmpl  = 1'b0;
      w_cmpl_idx  = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (r_state[i] == S_FILLING && r_src[i] == in_src && r_id[i] == in_id) begin
            w_any_match = 1'b1;
            w_match_idx = c_SLOT_W'(i);
         end
         if (r_state[i] == S_FREE) begin
            w_any_free = 1'b1;
            w_free_idx = c_SLOT_W'(i);
         end
         if (r_state[i] == S_COMPLETE) begin
            w_any_cmpl = 1'b1;
            w_cmpl_idx = c_SLOT_W'(i);
         end
      end
   end

   assign w_oob      = (32'(in_idx) >= 32'(FLITS_PER_PACKET));
   assign w_onehot   = FLITS_PER_PACKET'(1) << in_idx;
   assign in_ready   = w_any_match | w_any_free | w_oob;
   assign w_accept   = in_valid & in_ready;
   assign w_hit      = w_accept & ~w_oob & w_any_match;
   assign w_alloc    = w_accept & ~w_oob & ~w_any_match;
   assign w_dup      = w_hit & (|(r_mask[w_match_idx] & w_onehot));
   assign w_new_mask = r_mask[w_match_idx] | w_onehot;
   assign w_wr_slot  = w_alloc ? w_free_idx : w_match_idx;
   assign w_load     = ~r_out_valid | out_ready;
   assign w_unload   = w_load & w_any_cmpl;

   // A flit arriving in the eviction cycle keeps the slot alive.
   always_comb begin
      w_evict     = '0;
      w_evict_cnt = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (r_state[i] == S_FILLING && r_age[i] == c_AGE_MAX &&
             !(w_hit && w_match_idx == c_SLOT_W'(i))) begin
            w_evict[i]  = 1'b1;
            w_evict_cnt = w_evict_cnt + c_OCC_W'(1);
         end
      end
   end

   always_comb begin
      w_cmpl_data = '0;
      for (int f = 0; f < FLITS_PER_PACKET; f++) begin
         w_cmpl_data[(FLITS_PER_PACKET-1-f)*DATA_W +: DATA_W] = r_payload[w_cmpl_idx][f];
      end
   end

   always_ff @(posedge clk) begin
      if (w_alloc || (w_hit && !w_dup)) begin
         r_payload[w_wr_slot][in_idx] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SLOTS; s++) begin
            r_state[s] <= S_FREE;
            r_src[s]   <= '0;
            r_dst[s]   <= '0;
            r_id[s]    <= '0;
            r_mask[s]  <= '0;
            r_age[s]   <= '0;
         end
         r_out_valid     <= 1'b0;
         r_out_data      <= '0;
         r_out_src       <= '0;
         r_out_dst       <= '0;
         r_out_id        <= '0;
         r_occupancy     <= '0;
         r_drop_count    <= '0;
         r_dup_count     <= '0;
         r_timeout_count <= '0;
      end else begin
         for (int s = 0; s < SLOTS; s++) begin
            case (r_state[s])
               S_FREE: begin
                  if (w_alloc && w_free_idx == c_SLOT_W'(s)) begin
                     r_state[s] <= (w_onehot == c_FULL) ? S_COMPLETE : S_FILLING;
                     r_src[s]   <= in_src;
                     r_dst[s]   <= in_dst;
                     r_id[s]    <= in_id;
                     r_mask[s]  <= w_onehot;
                     r_age[s]   <= '0;
                  end
               end
               S_FILLING: begin
                  if (w_hit && w_match_idx == c_SLOT_W'(s)) begin
                     r_age[s]  <= '0;
                     r_mask[s] <= w_new_mask;
                     if (w_new_mask == c_FULL) r_state[s] <= S_COMPLETE;
                  end else if (w_evict[s]) begin
                     r_state[s] <= S_FREE;
                  end else begin
                     r_age[s] <= r_age[s] + c_AGE_W'(1);
                  end
               end
               S_COMPLETE: begin
                  if (w_unload && w_cmpl_idx == c_SLOT_W'(s)) r_state[s] <= S_FREE;
               end
               default: r_state[s] <= S_FREE;
            endcase
         end

         if (w_load) begin
            r_out_valid <= w_any_cmpl;
            if (w_any_cmpl) begin
               r_out_data <= w_cmpl_data;
               r_out_src  <= r_src[w_cmpl_idx];
               r_out_dst  <= r_dst[w_cmpl_idx];
               r_out_id   <= r_id[w_cmpl_idx];
            end
         end

         r_occupancy <= r_occupancy + c_OCC_W'(w_alloc) - c_OCC_W'(w_unload) - w_evict_cnt;

         if (w_accept && w_oob && r_drop_count != c_SAT) r_drop_count <= r_drop_count + 16'd1;
         if (w_dup && r_dup_count != c_SAT) r_dup_count <= r_dup_count + 16'd1;
         if ((|w_evict) && r_timeout_count != c_SAT) r_timeout_count <= r_timeout_count + 16'd1;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_data      = r_out_data;
   assign out_src       = r_out_src;
   assign out_dst       = r_out_dst;
   assign out_id        = r_out_id;
   assign occupancy     = r_occupancy;
   assign drop_count    = r_drop_count;
   assign dup_count     = r_dup_count;
   assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_packet_reassembler.sv
`default_nettype none
// Testbench for packet_reassembler: directed scenarios and randomized traffic
// compared every cycle against a slot-table model built from the packet rules.
module tb_packet_reassembler;

   localparam int F     = 9;
   localparam int SLOTS = 8;
   localparam int T     = 40;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_src;
   logic [2:0]  in_dst;
   logic [4:0]  in_id;
   logic [3:0]  in_idx;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [71:0] out_data;
   logic [2:0]  out_src;
   logic [2:0]  out_dst;
   logic [4:0]  out_id;
   logic [3:0]  occupancy;
   logic [15:0] drop_count;
   logic [15:0] dup_count;
   logic [15:0] timeout_count;

   packet_reassembler #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src(in_src), .in_dst(in_dst), .in_id(in_id), .in_idx(in_idx), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_dst(out_dst), .out_id(out_id),
      .occupancy(occupancy), .drop_count(drop_count), .dup_count(dup_count),
      .timeout_count(timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // Model: 0 = free, 1 = filling, 2 = complete
   int          m_st   [SLOTS];
   int          m_src  [SLOTS];
   int          m_dst  [SLOTS];
   int          m_id   [SLOTS];
   int          m_age  [SLOTS];
   bit          m_got  [SLOTS][F];
   logic [7:0]  m_pay  [SLOTS][F];
   bit          m_ov;
   logic [71:0] m_od;
   int          m_osrc, m_odst, m_oid;
   int          m_drop, m_dup, m_tmo;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int sat(input int x);
      return (x < 65535) ? x + 1 : x;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SLOTS; i++) begin
         m_st[i] = 0; m_age[i] = 0;
         for (int f = 0; f < F; f++) m_got[i][f] = 1'b0;
      end
      m_ov = 1'b0; m_od = '0; m_osrc = 0; m_odst = 0; m_oid = 0;
      m_drop = 0; m_dup = 0; m_tmo = 0;
   endtask

   function automatic bit m_ready();
      if (int'(in_idx) >= F) return 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
         if (m_st[i] == 0) return 1'b1;
         if (m_st[i] == 1 && m_src[i] == int'(in_src) && m_id[i] == int'(in_id)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int m_occ();
      int n = 0;
      for (int i = 0; i < SLOTS; i++) if (m_st[i] != 0) n++;
      return n;
   endfunction

   task automatic model_step();
      int cm, hit, j;
      bit pre_fill [SLOTS];
      bit any_to, full, take;
      if (!rst_n) begin
         model_reset();
         return;
      end
      cm = -1; hit = -1;
      take = !m_ov || out_ready;
      for (int i = 0; i < SLOTS; i++) pre_fill[i] = (m_st[i] == 1);
      if (take) for (int i = SLOTS - 1; i >= 0; i--) if (m_st[i] == 2) cm = i;
      if (in_valid && m_ready()) begin
         if (int'(in_idx) >= F) m_drop = sat(m_drop);
         else begin
            j = -1;
            for (int i = SLOTS - 1; i >= 0; i--)
               if (pre_fill[i] && m_src[i] == int'(in_src) && m_id[i] == int'(in_id)) j = i;
            if (j >= 0) begin
               m_age[j] = 0;
               if (m_got[j][in_idx]) m_dup = sat(m_dup);
               else begin m_got[j][in_idx] = 1'b1; m_pay[j][in_idx] = in_data; end
            end else begin
               for (int i = SLOTS - 1; i >= 0; i--) if (m_st[i] == 0) j = i;
               m_st[j] = 1; m_src[j] = in_src; m_dst[j] = in_dst; m_id[j] = in_id; m_age[j] = 0;
               for (int f = 0; f < F; f++) m_got[j][f] = 1'b0;
               m_got[j][in_idx] = 1'b1; m_pay[j][in_idx] = in_data;
            end
            hit = j;
            full = 1'b1;
            for (int f = 0; f < F; f++) if (!m_got[j][f]) full = 1'b0;
            if (full) m_st[j] = 2;
         end
      end
      any_to = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (pre_fill[i] && i != hit) begin
            if (m_age[i] >= T) begin m_st[i] = 0; any_to = 1'b1; end
            else m_age[i]++;
         end
      end
      if (any_to) m_tmo = sat(m_tmo);
      if (take) begin
         m_ov = (cm >= 0);
         if (cm >= 0) begin
            for (int f = 0; f < F; f++) m_od[(F-1-f)*8 +: 8] = m_pay[cm][f];
            m_osrc = m_src[cm]; m_odst = m_dst[cm]; m_oid = m_id[cm];
            m_st[cm] = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", out_data, m_od);
         chk("out_src", out_src, m_osrc);
         chk("out_dst", out_dst, m_odst);
         chk("out_id", out_id, m_oid);
      end
      chk("occupancy", occupancy, m_occ());
      chk("drop_count", drop_count, m_drop);
      chk("dup_count", dup_count, m_dup);
      chk("timeout_count", timeout_count, m_tmo);
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic tick();
      #1;
      compare_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input int s, input int d, input int id, input int idx, input int dat);
      in_valid = v; in_src = 3'(s); in_dst = 3'(d); in_id = 5'(id); in_idx = 4'(idx); in_data = 8'(dat);
   endtask

   task automatic send(input int s, input int d, input int id, input int idx, input int dat);
      drive(1'b1, s, d, id, idx, dat);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic send_pkt(input int s, input int d, input int id, input int base);
      for (int x = 0; x < F; x++) send(s, d, id, x, base + x);
   endtask

   task automatic do_reset();
      drive(1'b0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic random_phase(input int cycles, input int keys, input int rdy_pct);
      int k, idx;
      for (int c = 0; c < cycles; c++) begin
         k = $urandom_range(keys - 1);
         idx = ($urandom_range(99) < 88) ? $urandom_range(F - 1) : $urandom_range(15, F);
         drive($urandom_range(99) < 75, k % 8, $urandom_range(7), 8 + k / 8, idx, $urandom_range(255));
         out_ready = ($urandom_range(99) < rdy_pct);
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 72'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_occupancy", occupancy, 4'd0);
      chk("rst_counters", {drop_count, dup_count, timeout_count}, 48'h0);
      tick();
      rst_n = 1'b1;

      // In-order packet with two-edge latency.
      out_ready = 1'b1;
      send_pkt(3, 6, 5, 8'h10);
      chk("lat_not_yet", out_valid, 1'b0);
      idle(1);
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_data", out_data, 72'h101112131415161718);
      chk("lat_src", out_src, 3'd3);
      chk("lat_id", out_id, 5'd5);
      idle(1);
      chk("lat_pulse_end", out_valid, 1'b0);

      // All slots filling, a new packet is back-pressured until one drains.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(0, 1, i, 0, 8'h50 + i);
      drive(1'b1, 0, 1, 8, 0, 8'h77);
      #1;
      chk("full_backpressure", in_ready, 1'b0);
      tick();
      for (int x = 1; x < F; x++) send(0, 1, 3, x, 8'h60 + x);
      drive(1'b1, 0, 1, 8, 0, 8'h77);
      #1;
      chk("ready_while_complete", in_ready, 1'b0);
      tick();
      #1;
      chk("ready_after_free", in_ready, 1'b1);
      tick();
      chk("occ_after_ninth", occupancy, 4'd8);

      // Duplicate keeps first payload; out-of-range index is dropped.
      do_reset();
      out_ready = 1'b1;
      send(2, 4, 1, 2, 8'hAA);
      send(2, 4, 1, 2, 8'hBB);
      for (int x = 0; x < F; x++) if (x != 2) send(2, 4, 1, x, 8'hC0 + x);
      chk("dup_count_one", dup_count, 16'd1);
      idle(1);
      chk("dup_out_valid", out_valid, 1'b1);
      chk("dup_payload_kept", out_data[(F-1-2)*8 +: 8], 8'hAA);
      send(2, 4, 1, 12, 8'h99);
      chk("drop_count_one", drop_count, 16'd1);
      chk("drop_no_alloc", occupancy, 4'd0);

      // Timeout eviction of an abandoned slot.
      do_reset();
      send(5, 5, 7, 4, 8'h44);
      idle(T);
      chk("to_still_held", occupancy, 4'd1);
      chk("to_not_yet", timeout_count, 16'd0);
      idle(1);
      chk("to_evicted", occupancy, 4'd0);
      chk("to_count", timeout_count, 16'd1);
      chk("to_no_output", out_valid, 1'b0);

      // Held output, then two queued packets drain lowest slot first.
      do_reset();
      out_ready = 1'b0;
      send_pkt(1, 2, 1, 8'h20);
      idle(1);
      send(2, 3, 2, 0, 8'h30);
      send(4, 5, 4, 0, 8'h40);
      for (int x = 1; x < F; x++) send(4, 5, 4, x, 8'h40 + x);
      for (int x = 1; x < F; x++) send(2, 3, 2, x, 8'h30 + x);
      idle(5);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_id", out_id, 5'd1);
      chk("hold_data", out_data, 72'h202122232425262728);
      chk("hold_occ2", occupancy, 4'd2);
      out_ready = 1'b1;
      idle(1);
      chk("drain_first_id", out_id, 5'd2);
      chk("drain_occ1", occupancy, 4'd1);
      idle(1);
      chk("drain_second_id", out_id, 5'd4);
      chk("drain_occ0", occupancy, 4'd0);
      idle(1);
      chk("drain_empty", out_valid, 1'b0);

      // Asynchronous reset while busy.
      do_reset();
      out_ready = 1'b0;
      send_pkt(1, 1, 1, 8'h70);
      idle(1);
      send(2, 2, 2, 0, 8'h01);
      send(2, 2, 2, 0, 8'h02);
      send(3, 3, 3, 0, 8'h03);
      send(6, 6, 6, 0, 8'h06);
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_occ", occupancy, 4'd3);
      chk("pre_rst_dup", dup_count, 16'd1);
      drive(1'b0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_occ", occupancy, 4'd0);
      chk("async_rst_counters", {drop_count, dup_count, timeout_count}, 48'h0);
      chk("async_rst_ready", in_ready, 1'b1);
      model_reset();
      tick();
      rst_n = 1'b1;
      idle(2);

      // Randomized traffic: light contention, heavy contention, reset, mixed.
      random_phase(1500, 4, 60);
      random_phase(1500, 14, 30);
      do_reset();
      random_phase(600, 8, 80);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/packet_reassembler.md
PACKET_REASSEMBLER -- requirements
Module: packet_reassembler

Interface
REQ-001 Parameter NODE_COUNT, default 8: network node count; NODE_W = $clog2(NODE_COUNT).
REQ-002 Parameter PACKET_ID_WIDTH, default 5: packet ID width.
REQ-003 Parameter FLITS_PER_PACKET, default 9: flits per packet; IDX_W = $clog2(FLITS_PER_PACKET).
REQ-004 Parameter DATA_W, default 8: payload bits per flit.
REQ-005 Parameter SLOTS, default 8: reassembly slots; must be >= 2.
REQ-006 Parameter TIMEOUT_CYCLES, default 1024: idle cycles before an incomplete slot is evicted; must be >= 2.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 in_valid  in  1  flit present.
REQ-010 in_ready  out  1  flit accepted this cycle if in_valid also high.
REQ-011 in_src  in  NODE_W  source node.
REQ-012 in_dst  in  NODE_W  destination node.
REQ-013 in_id  in  PACKET_ID_WIDTH  packet ID.
REQ-014 in_idx  in  IDX_W  flit position in packet.
REQ-015 in_data  in  DATA_W  flit payload.
REQ-016 out_valid  out  1  reassembled packet present.
REQ-017 out_ready  in  1  consumer accepts packet.
REQ-018 out_data  out  FLITS_PER_PACKET*DATA_W  packet; flit 0 in the MSBs, flit FLITS_PER_PACKET-1 in the LSBs.
REQ-019 out_src, out_dst, out_id  out  NODE_W, NODE_W, PACKET_ID_WIDTH  packet header.
REQ-020 occupancy  out  $clog2(SLOTS+1)  number of non-FREE slots (registered).
REQ-021 drop_count, dup_count, timeout_count  out  16 each  saturating error counters.

Function
REQ-022 Each slot SHALL hold one state: FREE, FILLING or COMPLETE; it also holds a header, a FLITS_PER_PACKET-bit received mask, a payload array, and an age counter.
REQ-023 A slot matches a flit when the slot is FILLING, slot src == in_src and slot id == in_id; in_dst is not compared.
REQ-024 in_ready SHALL be combinational from the current state and the in_* fields.
- in_ready = 1 when a matching slot exists, or any slot is FREE, or in_idx >= FLITS_PER_PACKET.
- Otherwise in_ready = 0 (backpressure; no eviction by replacement).
REQ-025 Accepted flit with in_idx >= FLITS_PER_PACKET SHALL be discarded and increment drop_count.
REQ-026 Accepted flit for a matching slot whose mask bit is already set SHALL be discarded and increment dup_count; the slot's age is still cleared.
REQ-027 Accepted flit for a matching slot with the mask bit clear SHALL write the payload, set the mask bit and clear the age.
REQ-028 Accepted flit with no match SHALL allocate the lowest-index FREE slot: state FILLING, header from the in_* fields, mask = only bit in_idx, age = 0.
REQ-029 A slot whose mask is all-ones after an update SHALL enter COMPLETE at the same edge.
- Case FLITS_PER_PACKET = 1: COMPLETE directly on allocation.
REQ-030 Output register: when empty, or when out_valid && out_ready this cycle, it SHALL load the lowest-index COMPLETE slot; that slot becomes FREE at the same edge.
REQ-031 Latency: final flit accepted at edge N with an idle output register gives out_valid = 1 after edge N+1.
REQ-032 out_data and header SHALL stay stable while out_valid && !out_ready.
REQ-033 A slot freed at edge N SHALL NOT be allocatable until after edge N; in_ready uses pre-edge state.
REQ-034 Each FILLING slot's age SHALL increment every cycle it receives no flit, saturating at TIMEOUT_CYCLES.
- When age == TIMEOUT_CYCLES, the slot SHALL become FREE at the next edge and timeout_count increments.
- A flit accepted for that slot in the same cycle takes priority: the age clears and no eviction occurs.
REQ-035 When two counter events coincide in one cycle, each counter SHALL increment by at most 1; all counters saturate at 16'hFFFF.

Reset
REQ-036 While rst_n = 0, asynchronously:
- all slots FREE;
- out_valid = 0; out_data, out_src, out_dst, out_id = 0;
- occupancy = 0; all counters = 0;
- in_ready = 1.
REQ-037 Reset asserted mid-packet SHALL discard all partial and complete packets with no output.

Verification
REQ-038 In-order packet, src=3 id=5, flits idx 0..8 with data 8'h10..8'h18, out_ready=1 -> one out_valid pulse, out_data=72'h101112131415161718, out_src=3, out_id=5, two edges after the last flit.
REQ-039 Interleave 8 partial packets (distinct ids), then a 9th new id -> in_ready=0 for the 9th; completing any one packet frees a slot and the 9th is accepted one cycle later.
REQ-040 Send idx 2 twice (data AA then BB), then complete the packet -> dup_count=1, byte 2 of out_data = AA; send idx 12 -> drop_count=1, no state change.
REQ-041 Single flit, then idle for TIMEOUT_CYCLES+1 cycles -> slot freed, timeout_count=1, occupancy=0, no out_valid.
REQ-042 Two packets complete with out_ready=0 for 5 cycles -> out_valid held with the lower-slot packet stable; release out_ready -> second packet follows on the next cycle; occupancy steps 2,1,0.
REQ-043 Assert rst_n=0 while out_valid=1 and 3 slots are FILLING -> out_valid=0 and occupancy=0 immediately, counters 0.
